demux_scan_ctrl: RTL



---
 rtl/demux_pkg.sv | 13 +
 rtl/demux_scan_ctrl_if.sv | 24 ++
 rtl/demux_next_ch.sv | 24 ++
 rtl/demux_scan_ctrl.sv | 96 +++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants and state type for the demux scan controller
package demux_pkg;

    localparam int NCH   = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } scan_state_t;

endpackage

// File: rtl/demux_scan_ctrl_if.sv
// rtl/demux_scan_ctrl_if.sv - request and demux-drive signals of the scan controller
interface demux_scan_ctrl_if;
    import demux_pkg::*;

    logic             start;
    logic             abort;
    logic [NCH-1:0]   mask;
    logic [NCH-1:0]   pattern;
    logic [SEL_W-1:0] sel;
    logic             a;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, mask, pattern,
        input  sel, a, busy, done
    );

    modport slave (
        input  start, abort, mask, pattern,
        output sel, a, busy, done
    );

endinterface

// File: rtl/demux_next_ch.sv
// rtl/demux_next_ch.sv - priority finder for the next enabled channel
module demux_next_ch
    import demux_pkg::*;
(
    input  logic [NCH-1:0]   mask_q,
    input  logic [SEL_W-1:0] sel,
    input  logic             first,
    output logic [SEL_W-1:0] nxt_sel,
    output logic             nxt_valid
);

    // Scan from the top down so the lowest qualifying bit is the last one written.
    always_comb begin
        nxt_sel   = '0;
        nxt_valid = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask_q[i] && (first || (i > int'(sel)))) begin
                nxt_sel   = SEL_W'(i);
                nxt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_scan_ctrl.sv
// rtl/demux_scan_ctrl.sv - walks enabled demux channels with a fixed dwell per channel
module demux_scan_ctrl #(
    parameter int DWELL = 4,
    parameter int NCH   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    demux_scan_ctrl_if.slave  bus
);
    import demux_pkg::*;

    localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);

    scan_state_t      state;
    logic [NCH-1:0]   mask_q;
    logic [NCH-1:0]   pattern_q;
    logic [SEL_W-1:0] cur_sel;
    logic [7:0]       cnt;

    logic [NCH-1:0]   find_mask;
    logic             find_first;
    logic [SEL_W-1:0] nxt_sel;
    logic             nxt_valid;

    // In IDLE the first channel comes straight from the live mask so it can be
    // loaded on the same edge that latches the mask.
    assign find_first = (state == IDLE);
    assign find_mask  = find_first ? bus.mask : mask_q;

    demux_next_ch u_next_ch (
        .mask_q    (find_mask),
        .sel       (cur_sel),
        .first     (find_first),
        .nxt_sel   (nxt_sel),
        .nxt_valid (nxt_valid)
    );

    // Scan FSM plus output registers; outputs follow the state one cycle later,
    // except abort, which clears them on the same edge it cancels the scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mask_q    <= '0;
            pattern_q <= '0;
            cur_sel   <= '0;
            cnt       <= '0;
            bus.sel   <= '0;
            bus.a     <= 1'b0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        mask_q    <= bus.mask;
                        pattern_q <= bus.pattern;
                        if (nxt_valid) begin
                            state   <= SCAN;
                            cur_sel <= nxt_sel;
                            cnt     <= DWELL_M1;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                SCAN: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else if (nxt_valid) begin
                        cur_sel <= nxt_sel;
                        cnt     <= DWELL_M1;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            bus.sel  <= (state == SCAN) ? cur_sel :
                        (state == DONE) ? bus.sel : '0;
            bus.a    <= (state == SCAN) ? pattern_q[cur_sel] : 1'b0;
            bus.busy <= (state == SCAN);
            bus.done <= (state == DONE);

            if (bus.abort && (state != IDLE)) begin
                state    <= IDLE;
                bus.sel  <= '0;
                bus.a    <= 1'b0;
                bus.busy <= 1'b0;
                bus.done <= 1'b0;
            end
        end
    end

endmodule
